// File: rtl/line_shifter_pkg.sv
// Shared CGIA video constants and the per-cycle shifter action type used by line_shifter.
package line_shifter_pkg;

    localparam int LS_DEPTH  = 16;
    localparam int LS_WORD_W = 16;
    localparam int LS_PTR_W  = $clog2(LS_DEPTH);
    localparam int LS_CNT_W  = $clog2(LS_DEPTH + 1);

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_SHIFT,
        OP_LOAD,
        OP_UNDERRUN,
        OP_FLUSH
    } shift_op_e;

endpackage

// File: rtl/line_shifter_sync_fifo.sv
// Synchronous word FIFO with flush; read data is the registered head entry, so no write-to-read bypass.
module sync_fifo
    import line_shifter_pkg::*;
#(
    parameter int DEPTH  = LS_DEPTH,
    parameter int WORD_W = LS_WORD_W
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [WORD_W-1:0]            wdata_i,
    output logic [WORD_W-1:0]            rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign count_o = count;
    assign rdata_o = mem[rptr];

    // Flush and reset both win over a same-cycle push or pop.
    assign do_push = push_i & ~full_o & ~flush_i & ~reset_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i & ~reset_i;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_inc(wptr);
            if (do_pop)  rptr <= ptr_inc(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata_i;
    end

endmodule

// File: rtl/line_shifter.sv
// 1bpp scanline shifter: buffers framebuffer words and serialises them MSB-first, one pixel per clock.
module line_shifter
    import line_shifter_pkg::*;
#(
    parameter int DEPTH  = LS_DEPTH,
    parameter int WORD_W = LS_WORD_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [WORD_W-1:0] dat_i,
    input  logic              we_i,
    output logic              full_o,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              den_i,
    output logic              pixel_o,
    output logic              underrun_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BIT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sr;
    logic [BIT_W-1:0]  cnt;
    logic [WORD_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              active;
    logic              push;
    logic              pop;
    shift_op_e         op;

    assign active = den_i & ~hsync_i & ~vsync_i;
    assign push   = we_i & ~full_o & ~vsync_i;
    assign pop    = (op == OP_LOAD);

    sync_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (vsync_i),
        .wdata_i (dat_i),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (full_o)
    );

    // Pop only when the current word is exhausted, so a loaded word streams without a gap.
    always_comb begin
        op = OP_IDLE;
        if (vsync_i) begin
            op = OP_FLUSH;
        end else if (active) begin
            if (cnt != '0)       op = OP_SHIFT;
            else if (!fifo_empty) op = OP_LOAD;
            else                 op = OP_UNDERRUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sr         <= '0;
            cnt        <= '0;
            pixel_o    <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            pixel_o    <= 1'b0;
            underrun_o <= 1'b0;
            case (op)
                OP_SHIFT: begin
                    pixel_o <= sr[WORD_W-1];
                    sr      <= {sr[WORD_W-2:0], 1'b0};
                    cnt     <= cnt - 1'b1;
                end
                OP_LOAD: begin
                    pixel_o <= fifo_rdata[WORD_W-1];
                    sr      <= {fifo_rdata[WORD_W-2:0], 1'b0};
                    cnt     <= BIT_W'(WORD_W - 1);
                end
                OP_UNDERRUN: underrun_o <= 1'b1;
                OP_FLUSH:    cnt        <= '0;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_shifter.sv
// Scoreboard bench for line_shifter: a queue-based word/bit model predicts every cycle's outputs.
module tb_line_shifter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dat = '0;
    logic        we = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic        den = 1'b0;
    logic        full;
    logic        pixel;
    logic        underrun;

    always #5 clk = ~clk;

    line_shifter dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .dat_i      (dat),
        .we_i       (we),
        .full_o     (full),
        .hsync_i    (hsync),
        .vsync_i    (vsync),
        .den_i      (den),
        .pixel_o    (pixel),
        .underrun_o (underrun)
    );

    typedef struct {
        logic pix;
        logic und;
        logic full;
        int   cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_fifo[$];
    logic        m_bits[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    // Reference model: FIFO as a word queue, the shifter as a queue of pending bits.
    task automatic step(input logic r, input logic w, input logic [15:0] d,
                        input logic de, input logic hs, input logic vs);
        exp_t        e;
        logic [15:0] word;
        int          size0;
        @(negedge clk);
        reset = r; we = w; dat = d; den = de; hsync = hs; vsync = vs;
        e.pix = 1'b0; e.und = 1'b0; e.cyc = cyc;
        if (r) begin
            m_fifo.delete();
            m_bits.delete();
        end else begin
            size0 = m_fifo.size();
            if (de && !hs && !vs) begin
                if (m_bits.size() == 0 && size0 > 0) begin
                    word = m_fifo.pop_front();
                    for (int i = 15; i >= 0; i--) m_bits.push_back(word[i]);
                end
                if (m_bits.size() > 0) e.pix = m_bits.pop_front();
                else                   e.und = 1'b1;
            end
            if (vs) begin
                m_fifo.delete();
                m_bits.delete();
            end else if (w && size0 < 16) begin
                m_fifo.push_back(d);
            end
        end
        e.full = (m_fifo.size() == 16);
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic push_word(input logic [15:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_active(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int c, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, c, act, req);
        end
    endtask

    // Monitor: compares registered outputs just after each active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pixel_o", e.cyc, pixel, e.pix);
            check("underrun_o", e.cyc, underrun, e.und);
            check("full_o", e.cyc, full, e.full);
        end
    end

    initial begin
        logic r, w, de, hs, vs;
        step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);

        // Single word serialised MSB first, then one demand past its end.
        push_word(16'hA5F0);
        run_active(17);

        // Fill to full, attempt a 17th write, drain everything.
        for (int i = 0; i < 16; i++) push_word(16'h1000 + 16'(i * 16'h0111));
        push_word(16'h1234);
        push_word(16'h1234);
        run_active(16 * 16 + 1);

        // Empty FIFO under demand.
        run_active(3);

        // Mid-stream vsync with a concurrent write.
        for (int i = 0; i < 5; i++) push_word(16'(i * 16'h3333 + 16'h0F0F));
        run_active(20);
        step(1'b0, 1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b1);
        run_active(2);

        // Back-to-back words stream without a gap.
        push_word(16'hFFFF);
        push_word(16'h0000);
        run_active(33);

        // Push while demanding on an empty FIFO must still underrun.
        step(1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0);
        run_active(17);

        // Reset part-way through a word.
        push_word(16'hF00F);
        push_word(16'h7777);
        run_active(7);
        step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        run_active(2);

        // Randomised traffic including blanking, flushes, simultaneous push/pop and resets.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 499) == 0);
            w  = ($urandom_range(0, 99) < 55);
            de = ($urandom_range(0, 9) < 8);
            hs = ($urandom_range(0, 19) == 0);
            vs = ($urandom_range(0, 149) == 0);
            step(r, w, 16'($urandom), de, hs, vs);
        end
        step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_shifter.md
LINE_SHIFTER -- requirements
Module: line_shifter

Interface
REQ-001 SHALL have port clk_i  input  1  SYSCON clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_i  input  1  SYSCON reset, synchronous, active-high.
REQ-003 SHALL have port dat_i  input  16  framebuffer word returned by the slave.
REQ-004 SHALL have port we_i  input  1  word valid (fetcher cyc_o & slave ack_i).
REQ-005 SHALL have port full_o  output  1  FIFO holds 16 words; fetcher holds off.
REQ-006 SHALL have port hsync_i  input  1  CRTC HSYNC, active high.
REQ-007 SHALL have port vsync_i  input  1  CRTC VSYNC, active high.
REQ-008 SHALL have port den_i  input  1  REGSET display enable.
REQ-009 SHALL have port pixel_o  output  1  registered 1bpp pixel to video DAC.
REQ-010 SHALL have port underrun_o  output  1  one-cycle pulse: pixel demanded, no data available.
REQ-011 SHALL have parameters DEPTH=16 (FIFO entries) and WORD_W=16 (word and shifter width).

Function
REQ-012 SHALL keep a FIFO of DEPTH words and a fill count 0..16; full_o = (count==16), decoded combinationally from the registered count.
REQ-013 SHALL push dat_i when we_i & ~full_o & ~vsync_i; we_i while full SHALL drop the word and leave FIFO state unchanged.
REQ-014 SHALL define active = den_i & ~hsync_i & ~vsync_i, evaluated every cycle.
REQ-015 SHALL keep shift register sr[15:0] and bit count cnt 0..16.
REQ-016 On active & cnt!=0: pixel_o<=sr[15], sr<=sr<<1, cnt<=cnt-1.
REQ-017 On active & cnt==0 & FIFO non-empty: pop head word W; pixel_o<=W[15], sr<=W<<1, cnt<=15, giving gap-free output at one pixel per clock.
REQ-018 On active & cnt==0 & FIFO empty: pixel_o<=0 and underrun_o<=1 for that cycle; no other state change.
REQ-019 On ~active: pixel_o<=0; sr, cnt and FIFO contents SHALL hold, except as REQ-020 requires.
REQ-020 On vsync_i: flush FIFO (count<=0, pointers<=0) and set cnt<=0; a write in the same cycle SHALL be dropped.
REQ-021 Push and pop in the same cycle SHALL both occur, leaving count unchanged.
REQ-022 Pop SHALL read only words stored in earlier cycles, with no write-to-read bypass; a push into an empty FIFO in the same cycle as a demand SHALL produce an underrun.
REQ-023 Read and write pointers SHALL be 4 bits and wrap 15->0; count SHALL be 5 bits.
REQ-024 Latency: a word pushed in cycle N SHALL be poppable in cycle N+1 at the earliest, and its first pixel SHALL appear on pixel_o after that pop edge.

Reset
REQ-025 On reset_i: count=0, pointers=0, cnt=0, sr=0, pixel_o=0, underrun_o=0, so full_o=0.
REQ-026 reset_i SHALL override every other input in the same cycle, including a mid-line reset with a partly shifted word.
REQ-027 FIFO storage RAM SHALL NOT require reset.

Structure
REQ-028 SHALL place DEPTH, WORD_W and the pointer/count widths in the shared CGIA constants include file.
REQ-029 SHALL instantiate one sub-module, sync_fifo (push/pop/flush, count, data out), and keep the shifter and control logic in line_shifter.

Verification
REQ-030 Push 0xA5F0, then hold active 16 cycles -> pixel_o emits 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0 with no underrun.
REQ-031 Push 16 words, then assert we_i with 0x1234 -> full_o=1, word dropped; drained order matches the first 16 words.
REQ-032 Active with FIFO empty for 3 cycles -> underrun_o high all 3 cycles, pixel_o=0.
REQ-033 Push 5 words, take 20 active cycles, then pulse vsync_i together with we_i -> count=0, cnt=0, next active cycle underruns.
REQ-034 Push 0xFFFF and 0x0000 back-to-back, 32 active cycles -> 16 ones, then 16 zeros, no gap.
REQ-035 Assert reset_i after 7 pixels of a word -> all REQ-025 values hold the following cycle.
